load_store_unit: RTL and testbench

- Parametrised MEM-stage load/store engine for the pipelined rv32i/rv64i core.
- Replaces the single-cycle data-memory path with a handshaked, variable-latency access, and adds:
  - load byte/half/word (and double) extraction with sign or zero extension;
  - illegal-size and bus-timeout error reporting;
  - a stall output to freeze the upstream pipeline.
- Sits between the EX-MEM register and the data memory; its response feeds the MEM-WB register.

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store engine: handshaked variable-latency data-memory access with
// lane steering, load extension, and error reporting. Optional macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ip_req_valid,
  output logic              op_req_ready,
  input  logic              ip_req_is_store,
  input  logic [2:0]        ip_req_funct3,
  input  logic [ADDR_W-1:0] ip_req_addr,
  input  logic [XLEN-1:0]   ip_req_wdata,
  input  logic [4:0]        ip_req_rd,
  output logic              op_resp_valid,
  output logic [4:0]        op_resp_rd,
  output logic [XLEN-1:0]   op_resp_data,
  output logic              op_resp_error,
  output logic              op_stall,
  output logic [ADDR_W-1:0] op_data_addr,
  output logic              op_data_rd,
  output logic              op_data_wr,
  output logic [XLEN/8-1:0] op_data_mask,
  output logic [XLEN-1:0]   op_data_from_proc,
  input  logic              ip_data_valid,
  input  logic [XLEN-1:0]   ip_data_from_dmem
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state;
  logic [2:0]         req_f3_p0;
  logic [OFF_W-1:0]   req_off_p0;
  logic [4:0]         req_rd_p0;
  logic               req_store_p0;
  logic [CNT_W-1:0]   tmo_cnt;

  logic [1:0]         sz;
  logic [OFF_W-1:0]   req_off, align_mask, eff_off;
  logic               illegal, req_err;
  logic [NB-1:0]      req_mask;
  logic [XLEN-1:0]    req_wdata;
  logic [ADDR_W-1:0]  req_addr_al;

  // Shift the bus word down to the accessed lanes, then sign- or zero-extend.
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] raw,
                                                  input logic [2:0] f3,
                                                  input logic [OFF_W-1:0] off);
    logic [XLEN-1:0]   sh;
    logic signed [7:0]  sb;
    logic signed [15:0] sh16;
    logic signed [31:0] sw;
    sh   = raw >> {off, 3'b000};
    sb   = sh[7:0];
    sh16 = sh[15:0];
    sw   = sh[31:0];
    case (f3[1:0])
      2'b00:   if (f3[2]) extend_load = XLEN'(sh[7:0]);  else extend_load = XLEN'(sb);
      2'b01:   if (f3[2]) extend_load = XLEN'(sh[15:0]); else extend_load = XLEN'(sh16);
      2'b10:   if (f3[2]) extend_load = XLEN'(sh[31:0]); else extend_load = XLEN'(sw);
      default: extend_load = sh;
    endcase
  endfunction

  always_comb begin
    sz          = ip_req_funct3[1:0];
    req_off     = ip_req_addr[OFF_W-1:0];
    align_mask  = OFF_W'((1 << sz) - 1);
    eff_off     = req_off & ~align_mask;
    illegal     = (ip_req_funct3 == 3'b111) || (ip_req_is_store && ip_req_funct3[2]) ||
                  ((XLEN == 32) && (ip_req_funct3 == 3'b011 || ip_req_funct3 == 3'b110));
    req_mask    = NB'((1 << (1 << sz)) - 1) << eff_off;
    req_wdata   = ip_req_wdata << {eff_off, 3'b000};
    req_addr_al = {ip_req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
`ifdef LSU_MISALIGN_TRAP_EN
    req_err     = illegal || (|(req_off & align_mask));
`else
    req_err     = illegal;
`endif
  end

  assign op_req_ready = reset && (state == IDLE);
  assign op_stall     = (state != IDLE) || !reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      req_f3_p0         <= '0;
      req_off_p0        <= '0;
      req_rd_p0         <= '0;
      req_store_p0      <= 1'b0;
      tmo_cnt           <= '0;
      op_resp_valid     <= 1'b0;
      op_resp_rd        <= '0;
      op_resp_data      <= '0;
      op_resp_error     <= 1'b0;
      op_data_addr      <= '0;
      op_data_rd        <= 1'b0;
      op_data_wr        <= 1'b0;
      op_data_mask      <= '0;
      op_data_from_proc <= '0;
    end else begin
      case (state)
        // Request capture: errors bypass the memory entirely.
        IDLE: if (ip_req_valid) begin
          req_f3_p0    <= ip_req_funct3;
          req_off_p0   <= eff_off;
          req_rd_p0    <= ip_req_rd;
          req_store_p0 <= ip_req_is_store;
          tmo_cnt      <= '0;
          if (req_err) begin
            state         <= RESP;
            op_resp_valid <= 1'b1;
            op_resp_error <= 1'b1;
            op_resp_rd    <= ip_req_rd;
            op_resp_data  <= '0;
          end else begin
            state             <= ACCESS;
            op_data_rd        <= !ip_req_is_store;
            op_data_wr        <= ip_req_is_store;
            op_data_addr      <= req_addr_al;
            op_data_mask      <= req_mask;
            op_data_from_proc <= ip_req_is_store ? req_wdata : '0;
          end
        end
        // Memory access: data valid wins over a simultaneous timeout.
        ACCESS: begin
          if (ip_data_valid || (TIMEOUT_CYCLES != 0 && tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            state             <= RESP;
            op_data_rd        <= 1'b0;
            op_data_wr        <= 1'b0;
            op_data_addr      <= '0;
            op_data_mask      <= '0;
            op_data_from_proc <= '0;
            op_resp_valid     <= 1'b1;
            op_resp_error     <= !ip_data_valid;
            if (ip_data_valid) begin
              op_resp_rd   <= req_store_p0 ? 5'd0 : req_rd_p0;
              op_resp_data <= req_store_p0 ? '0 : extend_load(ip_data_from_dmem, req_f3_p0, req_off_p0);
            end else begin
              op_resp_rd   <= req_rd_p0;
              op_resp_data <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        // Response pulse lasts one cycle.
        RESP: begin
          state         <= IDLE;
          op_resp_valid <= 1'b0;
          op_resp_error <= 1'b0;
          op_resp_rd    <= '0;
          op_resp_data  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit: a 32-bit instance (timeout 4) and a
// 64-bit instance share request/memory stimulus; expected responses are queued at issue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_req_valid, b_req_valid, dv;
  logic        is_store;
  logic [2:0]  f3;
  logic [31:0] addr;
  logic [63:0] wdata, dmem;
  logic [4:0]  rd;

  logic        a_ready, a_resp_valid, a_resp_error, a_stall, a_drd, a_dwr;
  logic [4:0]  a_resp_rd;
  logic [31:0] a_resp_data, a_daddr, a_fproc;
  logic [3:0]  a_mask;
  logic        b_ready, b_resp_valid, b_resp_error, b_stall, b_drd, b_dwr;
  logic [4:0]  b_resp_rd;
  logic [63:0] b_resp_data, b_fproc;
  logic [31:0] b_daddr;
  logic [7:0]  b_mask;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .ip_req_valid(a_req_valid), .op_req_ready(a_ready),
    .ip_req_is_store(is_store), .ip_req_funct3(f3), .ip_req_addr(addr),
    .ip_req_wdata(wdata[31:0]), .ip_req_rd(rd), .op_resp_valid(a_resp_valid),
    .op_resp_rd(a_resp_rd), .op_resp_data(a_resp_data), .op_resp_error(a_resp_error),
    .op_stall(a_stall), .op_data_addr(a_daddr), .op_data_rd(a_drd), .op_data_wr(a_dwr),
    .op_data_mask(a_mask), .op_data_from_proc(a_fproc), .ip_data_valid(dv),
    .ip_data_from_dmem(dmem[31:0]));

  load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(255)) u_b (
    .clk(clk), .reset(reset), .ip_req_valid(b_req_valid), .op_req_ready(b_ready),
    .ip_req_is_store(is_store), .ip_req_funct3(f3), .ip_req_addr(addr),
    .ip_req_wdata(wdata), .ip_req_rd(rd), .op_resp_valid(b_resp_valid),
    .op_resp_rd(b_resp_rd), .op_resp_data(b_resp_data), .op_resp_error(b_resp_error),
    .op_stall(b_stall), .op_data_addr(b_daddr), .op_data_rd(b_drd), .op_data_wr(b_dwr),
    .op_data_mask(b_mask), .op_data_from_proc(b_fproc), .ip_data_valid(dv),
    .ip_data_from_dmem(dmem));

  logic        sel;
  logic        v_ready, v_resp_valid, v_resp_error, v_stall, v_drd, v_dwr;
  logic [4:0]  v_resp_rd;
  logic [63:0] v_resp_data, v_fproc;
  logic [31:0] v_daddr;
  logic [7:0]  v_mask;

  always_comb begin
    v_ready      = sel ? b_ready      : a_ready;
    v_resp_valid = sel ? b_resp_valid : a_resp_valid;
    v_resp_error = sel ? b_resp_error : a_resp_error;
    v_stall      = sel ? b_stall      : a_stall;
    v_drd        = sel ? b_drd        : a_drd;
    v_dwr        = sel ? b_dwr        : a_dwr;
    v_resp_rd    = sel ? b_resp_rd    : a_resp_rd;
    v_resp_data  = sel ? b_resp_data  : {32'h0, a_resp_data};
    v_fproc      = sel ? b_fproc      : {32'h0, a_fproc};
    v_daddr      = sel ? b_daddr      : a_daddr;
    v_mask       = sel ? b_mask       : {4'h0, a_mask};
  end

  // Memory model: asserts valid after wait_n strobe cycles; -1 never answers.
  int wait_n = 0;
  int scnt   = 0;
  always @(negedge clk) begin
    if (v_drd || v_dwr) begin
      dv = (scnt == wait_n);
      scnt++;
    end else begin
      dv   = 1'b0;
      scnt = 0;
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
    int          lat;
    int          strobes;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int passes = 0;

  function automatic exp_t mk(input logic [4:0] r, input logic [63:0] d, input logic e,
                              input int l, input int s);
    exp_t x;
    x.rd = r; x.data = d; x.err = e; x.lat = l; x.strobes = s;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called on a negedge while the selected unit is idle; returns on the negedge after accept.
  task automatic issue(input logic s, input logic st, input logic [2:0] f, input logic [31:0] ad,
                       input logic [63:0] wd, input logic [4:0] r, input int wn, input exp_t e);
    sel = s; is_store = st; f3 = f; addr = ad; wdata = wd; rd = r; wait_n = wn;
    if (s) b_req_valid = 1'b1; else a_req_valid = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  task automatic collect(input string tag);
    int   lat;
    int   strobes;
    exp_t e;
    lat = 1;
    strobes = 0;
    while (!v_resp_valid && lat < 40) begin
      if (v_drd || v_dwr) strobes++;
      @(negedge clk);
      lat++;
    end
    e = sbq.pop_front();
    chk({tag, "_valid"}, v_resp_valid, 1);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_strobes"}, strobes, e.strobes);
    chk({tag, "_rd"}, v_resp_rd, e.rd);
    chk({tag, "_data"}, v_resp_data, e.data);
    chk({tag, "_err"}, v_resp_error, e.err);
    @(negedge clk);
    chk({tag, "_pulse"}, v_resp_valid, 0);
    chk({tag, "_ready"}, v_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; sel = 1'b0; a_req_valid = 1'b0; b_req_valid = 1'b0;
    is_store = 1'b0; f3 = 3'b0; addr = '0; wdata = '0; rd = '0; dmem = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", a_ready, 0);
    chk("rst_ready_b", b_ready, 0);
    chk("rst_stall", a_stall, 1);
    chk("rst_resp", a_resp_valid, 0);
    chk("rst_strobe", {a_drd, a_dwr, a_mask}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_ready", a_ready, 1);
    chk("idle_stall", a_stall, 0);

    // SB at 0x1003, memory answers after two wait cycles
    issue(0, 1, 3'b000, 32'h1003, 64'hA5, 5'd7, 2, mk(5'd0, 64'h0, 0, 4, 3));
    chk("sb_wr", {v_dwr, v_drd}, 2'b10);
    chk("sb_mask", v_mask, 8'h08);
    chk("sb_addr", v_daddr, 32'h1000);
    chk("sb_wdata", v_fproc, 64'hA500_0000);
    chk("sb_stall", {v_stall, v_ready}, 2'b10);
    collect("sb");

    dmem = 64'h8001_1234;
    issue(0, 0, 3'b001, 32'h2002, 64'h0, 5'd5, 0, mk(5'd5, 64'hFFFF_8001, 0, 2, 1));
    chk("lh_rd", {v_drd, v_dwr}, 2'b10);
    chk("lh_mask", v_mask, 8'h0C);
    chk("lh_addr", v_daddr, 32'h2000);
    collect("lh");
    issue(0, 0, 3'b101, 32'h2002, 64'h0, 5'd5, 0, mk(5'd5, 64'h0000_8001, 0, 2, 1));
    collect("lhu");
    issue(0, 0, 3'b000, 32'h2000, 64'h0, 5'd6, 1, mk(5'd6, 64'h34, 0, 3, 2));
    collect("lb");

    dmem = 64'hDEAD_BEEF;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 0, 3'b010, 32'h3001, 64'h0, 5'd8, 0, mk(5'd8, 64'h0, 1, 1, 0));
    chk("lwmis_nostrobe", {v_drd, v_dwr}, 2'b00);
    collect("lwmis");
`else
    issue(0, 0, 3'b010, 32'h3001, 64'h0, 5'd8, 0, mk(5'd8, 64'hDEAD_BEEF, 0, 2, 1));
    chk("lwmis_addr", v_daddr, 32'h3000);
    chk("lwmis_mask", v_mask, 8'h0F);
    collect("lwmis");
`endif

    // Timeout of 4 cycles with no answer, then an answer on the 4th cycle
    issue(0, 0, 3'b010, 32'h4000, 64'h0, 5'd9, -1, mk(5'd9, 64'h0, 1, 5, 4));
    collect("tmo");
    dmem = 64'h1234_5678;
    issue(0, 0, 3'b010, 32'h4000, 64'h0, 5'd9, 3, mk(5'd9, 64'h1234_5678, 0, 5, 4));
    collect("tmo_edge");

    issue(0, 0, 3'b011, 32'h4000, 64'h0, 5'd3, 0, mk(5'd3, 64'h0, 1, 1, 0));
    collect("ld32_illegal");

    // Reset in the middle of an access
    issue(0, 0, 3'b010, 32'h5000, 64'h0, 5'd11, -1, mk(5'd11, 64'h0, 1, 5, 4));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_strobe", {v_drd, v_dwr, v_mask}, 0);
    chk("midrst_addr", v_daddr, 0);
    chk("midrst_ready", {v_ready, v_stall, v_resp_valid}, 3'b010);
    sbq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_noresp", v_resp_valid, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("postrst_ready", {v_ready, v_stall}, 2'b10);
    dmem = 64'hCAFE_F00D;
    issue(0, 0, 3'b010, 32'h5004, 64'h0, 5'd12, 1, mk(5'd12, 64'hCAFE_F00D, 0, 3, 2));
    chk("postrst_addr", v_daddr, 32'h5004);
    collect("postrst");

    // 64-bit instance
    dmem = 64'h1122_3344_5566_7788;
    issue(1, 0, 3'b011, 32'h10, 64'h0, 5'd4, 0, mk(5'd4, 64'h1122_3344_5566_7788, 0, 2, 1));
    chk("ld_mask", v_mask, 8'hFF);
    chk("ld_addr", v_daddr, 32'h10);
    collect("ld");
    dmem = 64'h8000_0000_1234_5678;
    issue(1, 0, 3'b110, 32'h14, 64'h0, 5'd2, 0, mk(5'd2, 64'h0000_0000_8000_0000, 0, 2, 1));
    chk("lwu_mask", v_mask, 8'hF0);
    chk("lwu_addr", v_daddr, 32'h10);
    collect("lwu");
    issue(1, 0, 3'b010, 32'h14, 64'h0, 5'd2, 0, mk(5'd2, 64'hFFFF_FFFF_8000_0000, 0, 2, 1));
    collect("lw64");
    issue(1, 1, 3'b110, 32'h14, 64'h55, 5'd6, 0, mk(5'd6, 64'h0, 1, 1, 0));
    collect("sw_illegal");
    issue(1, 1, 3'b001, 32'h16, 64'hBEEF, 5'd1, 0, mk(5'd0, 64'h0, 0, 2, 1));
    chk("sh64_mask", v_mask, 8'hC0);
    chk("sh64_wdata", v_fproc, 64'hBEEF_0000_0000_0000);
    collect("sh64");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
